// File: rtl/lfa_pkg.sv
// ---------------------------------------------------------------------------
// lfa_pkg
// Shared definitions for the Ladner-Fischer adder Wishbone initiator.
//
// Contents:
//   lfa_state_e  - initiator sequence states (IDLE, WR_AB, WR_CIN, RD_RES)
//   LFA_OFS_*    - responder register offsets relative to the base address
//   LFA_COUT_BIT - bit position of the carry-out in the result read word
//   LFA_TMO_W    - width of the per-phase timeout counter (TIMEOUT <= 255)
//   lfa_golden   - reference 17-bit {cout, sum} of a + b + cin
// ---------------------------------------------------------------------------
package lfa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_AB  = 2'd1,
    WR_CIN = 2'd2,
    RD_RES = 2'd3
  } lfa_state_e;

  // Responder register map, byte offsets from BASE_ADR
  localparam logic [31:0] LFA_OFS_AB  = 32'h0000_0000;
  localparam logic [31:0] LFA_OFS_CIN = 32'h0000_0004;
  localparam logic [31:0] LFA_OFS_RES = 32'h0000_0008;

  localparam int LFA_COUT_BIT = 16;

  localparam int LFA_TMO_W = 8;

  // Reference addition used by the optional self-check
  function automatic logic [16:0] lfa_golden(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic        cin);
    return {1'b0, a} + {1'b0, b} + {16'b0, cin};
  endfunction

endpackage

// File: rtl/lfa_wb_timeout.sv
// ---------------------------------------------------------------------------
// lfa_wb_timeout
// Loadable down-counter that flags when a bus phase has waited its full
// allowance without an acknowledge.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-high reset
//   load_i      in   reload the counter (phase entry)
//   load_val_i  in   value loaded on load_i (the wait allowance in cycles)
//   en_i        in   count down this cycle (a phase is in progress)
//   expired_o   out  the edge ending this cycle is the last allowed one
// ---------------------------------------------------------------------------
module lfa_wb_timeout
  import lfa_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [LFA_TMO_W-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expired_o
);

  logic [LFA_TMO_W-1:0] cnt_q;
  logic [LFA_TMO_W-1:0] cnt_d;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds N at phase entry, so a value of 1 marks the Nth
  // waiting cycle: the phase gives up at the edge closing that cycle.
  assign expired_o = en_i && (cnt_q == LFA_TMO_W'(1));

endmodule

// File: rtl/lfa_wb_initiator.sv
// ---------------------------------------------------------------------------
// lfa_wb_initiator
// Wishbone traffic generator for the 16-bit Ladner-Fischer adder responder.
// A start request writes {b, a} to BASE_ADR+0 and cin to BASE_ADR+4, then
// reads {.., cout, sum} from BASE_ADR+8. cyc/stb stay high across all three
// back-to-back classic cycles. A phase without an acknowledge inside TIMEOUT
// cycles aborts the sequence with a sticky error.
//
// Optional feature macro: LFA_WB_INITIATOR_CHECK_EN
//   defined   - a local golden adder compares the read result and drives
//               mismatch_o
//   undefined - mismatch_o is tied low
//
// Parameters:
//   BASE_ADR  responder base address
//   TIMEOUT   cycles allowed per phase for an acknowledge (1..255)
//
// Ports:
//   wb_clk_i    in   clock
//   wb_rst_i    in   asynchronous active-high reset
//   start_i     in   start request, honoured only while idle
//   a_i, b_i    in   16-bit operands
//   cin_i       in   carry-in
//   busy_o      out  sequence in progress
//   done_o      out  one-cycle completion pulse (success or timeout)
//   sum_o       out  last successfully read sum
//   cout_o      out  last successfully read carry-out
//   err_o       out  sticky timeout flag, cleared by the next start
//   mismatch_o  out  read result disagreed with the golden model
//   wbm_*       Wishbone master port towards the adder responder
// ---------------------------------------------------------------------------
module lfa_wb_initiator
  import lfa_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sum_o,
  output logic        cout_o,
  output logic        err_o,
  output logic        mismatch_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [LFA_TMO_W-1:0] TMO_LOAD = LFA_TMO_W'(TIMEOUT);

  lfa_state_e  state_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        cin_q;
  logic [15:0] sum_q;
  logic        cout_q;
  logic        err_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;

  logic        tmo_expired;
  logic        tmo_load;
  logic        accept;
  logic        phase_ack;
  logic        rd_done;
  logic        tmo_abort;

  // The read word's upper bits carry nothing of interest.
  logic [14:0] unused_dat;
  assign unused_dat = wbm_dat_i[31:17];

  // An ack only counts while a phase is on the bus; acks seen in IDLE are
  // stray and ignored. An ack arriving on the last allowed cycle still wins
  // over the timeout.
  assign accept    = (state_q == IDLE) && start_i;
  assign phase_ack = busy_q && wbm_ack_i;
  assign rd_done   = (state_q == RD_RES) && wbm_ack_i;
  assign tmo_abort = busy_q && !wbm_ack_i && tmo_expired;

  // Every phase entry (start acceptance or an ack that moves to another
  // bus phase) restarts the wait allowance.
  assign tmo_load = accept || (phase_ack && (state_q != RD_RES));

  lfa_wb_timeout u_timeout (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .en_i       (busy_q),
    .expired_o  (tmo_expired)
  );

  // Sequencer. Bus signals are registered together with the state so each
  // phase presents its address/data from the cycle it is entered; leaving
  // the last phase (by ack or by timeout) clears the bus in the same edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            cin_q   <= cin_i;
            err_q   <= 1'b0;
            state_q <= WR_AB;
            busy_q  <= 1'b1;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            sel_q   <= 4'hF;
            adr_q   <= BASE_ADR + LFA_OFS_AB;
            dat_q   <= {b_i, a_i};
          end
        end

        WR_AB: begin
          if (wbm_ack_i) begin
            state_q <= WR_CIN;
            adr_q   <= BASE_ADR + LFA_OFS_CIN;
            dat_q   <= {31'b0, cin_q};
          end
        end

        WR_CIN: begin
          if (wbm_ack_i) begin
            state_q <= RD_RES;
            we_q    <= 1'b0;
            adr_q   <= BASE_ADR + LFA_OFS_RES;
            dat_q   <= '0;
          end
        end

        RD_RES: begin
          if (wbm_ack_i) begin
            sum_q   <= wbm_dat_i[15:0];
            cout_q  <= wbm_dat_i[LFA_COUT_BIT];
            done_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Timeout abort from any bus phase: results are left untouched.
      if (tmo_abort) begin
        err_q   <= 1'b1;
        done_q  <= 1'b1;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
        sel_q   <= '0;
        adr_q   <= '0;
        dat_q   <= '0;
      end
    end
  end

`ifdef LFA_WB_INITIATOR_CHECK_EN
  logic [16:0] golden;
  logic        mismatch_q;

  assign golden = lfa_golden(a_q, b_q, cin_q);

  // Verdict refreshes on the same edges that raise done_o; a timed-out
  // operation has no result to judge, so it reads as no mismatch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mismatch_q <= 1'b0;
    end else if (rd_done) begin
      mismatch_q <= (wbm_dat_i[16:0] != golden);
    end else if (tmo_abort) begin
      mismatch_q <= 1'b0;
    end
  end

  assign mismatch_o = mismatch_q;
`else
  logic unused_rd_done;
  assign unused_rd_done = rd_done;
  assign mismatch_o     = 1'b0;
`endif

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign err_o     = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_lfa_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_lfa_wb_initiator
// Self-checking bench for lfa_wb_initiator. A configurable responder answers
// the bus (wait states, a stalled phase, or a forced read value), and a
// timeline model predicts every output from the operation's schedule.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfa_wb_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;
  logic        mm;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;

  int errCount   = 0;
  int checkCount = 0;

  // Responder / scenario configuration, set before each start
  int          cfgWaits      = 0;
  bit          cfgStallEn    = 1'b0;
  int          cfgStallPhase = 0;
  bit          cfgOvrEn      = 1'b0;
  logic [31:0] cfgOvrVal     = '0;
  bit          idleAck       = 1'b0;

  lfa_wb_initiator #(
    .BASE_ADR (BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .busy_o     (busy),
    .done_o     (done),
    .sum_o      (sum),
    .cout_o     (cout),
    .err_o      (err),
    .mismatch_o (mm),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_dat_i  (rdat),
    .wbm_ack_i  (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: acks after cfgWaits wait cycles, never acks the stalled
  // phase, returns either the true sum of what was written or a forced word.
  int          rspWait;
  logic [15:0] rspA;
  logic [15:0] rspB;
  logic        rspCin;
  logic        stalled;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rspWait <= 0;
      rspA    <= '0;
      rspB    <= '0;
      rspCin  <= 1'b0;
    end else begin
      if (!stb || ack) rspWait <= 0;
      else             rspWait <= rspWait + 1;
      if (stb && ack && we) begin
        if (adr == BASE)            begin rspA <= wdat[15:0]; rspB <= wdat[31:16]; end
        else if (adr == BASE + 32'h4) rspCin <= wdat[0];
      end
    end
  end

  assign stalled = cfgStallEn && (adr == BASE + 32'(4 * cfgStallPhase));
  assign ack     = idleAck || (stb && (rspWait == cfgWaits) && !stalled);
  assign rdat    = cfgOvrEn ? cfgOvrVal
                            : {15'b0, 17'(rspA) + 17'(rspB) + 17'(rspCin)};

  // Timeline model: an accepted operation spends (waits+1) cycles per bus
  // phase; a stalled phase lasts TMO cycles and then ends the operation.
  bit          mBusy = 1'b0;
  int          mK    = 0;
  logic [15:0] mA    = '0;
  logic [15:0] mB    = '0;
  logic        mCin  = 1'b0;
  logic [15:0] mSum  = '0;
  logic        mCout = 1'b0;
  logic        mErr  = 1'b0;
  logic        mMm   = 1'b0;
  logic        mDone = 1'b0;
  int          span;
  int          doneK;
  int          phase;
  logic [31:0] rv;
  logic [16:0] gold;
  logic [31:0] expDat;

  always @(negedge clk) begin
    span  = cfgWaits + 1;
    doneK = cfgStallEn ? cfgStallPhase * span + TMO : 3 * span;
    mDone = 1'b0;
    if (rst) begin
      mBusy = 1'b0; mK = 0; mA = '0; mB = '0; mCin = 1'b0;
      mSum = '0; mCout = 1'b0; mErr = 1'b0; mMm = 1'b0;
    end else begin
      if (!mBusy) begin
        if (start) begin
          mBusy = 1'b1; mK = 0; mA = a; mB = b; mCin = cin; mErr = 1'b0;
        end
      end else begin
        mK++;
      end
      if (mBusy && mK == doneK) begin
        mBusy = 1'b0;
        mDone = 1'b1;
        if (cfgStallEn) begin
          mErr = 1'b1;
          mMm  = 1'b0;
        end else begin
          gold  = 17'(mA) + 17'(mB) + 17'(mCin);
          rv    = cfgOvrEn ? cfgOvrVal : {15'b0, gold};
          mSum  = rv[15:0];
          mCout = rv[16];
`ifdef LFA_WB_INITIATOR_CHECK_EN
          mMm   = (rv[16:0] != gold);
`else
          mMm   = 1'b0;
`endif
        end
      end
    end
    phase = (cfgStallEn && mK >= cfgStallPhase * span) ? cfgStallPhase : mK / span;

    checkOutput("busy_o",     32'(busy), 32'(mBusy));
    checkOutput("done_o",     32'(done), 32'(mDone));
    checkOutput("sum_o",      32'(sum),  32'(mSum));
    checkOutput("cout_o",     32'(cout), 32'(mCout));
    checkOutput("err_o",      32'(err),  32'(mErr));
    checkOutput("mismatch_o", 32'(mm),   32'(mMm));
    checkOutput("wbm_cyc_o",  32'(cyc),  32'(mBusy));
    checkOutput("wbm_stb_o",  32'(stb),  32'(mBusy));
    checkOutput("wbm_sel_o",  32'(sel),  mBusy ? 32'hF : 32'h0);
    checkOutput("wbm_we_o",   32'(we),   32'(mBusy && phase < 2));
    checkOutput("wbm_adr_o",  adr,       mBusy ? BASE + 32'(4 * phase) : 32'h0);
    if (!mBusy || phase < 2) begin
      expDat = !mBusy ? 32'h0 : (phase == 0) ? {mB, mA} : {31'b0, mCin};
      checkOutput("wbm_dat_o", wdat, expDat);
    end
  end

  // Runs one operation and waits (bounded) for done; returns cycles from
  // the accepting edge to the done edge. pokeBusy fires extra start pulses
  // with different operands while the operation is running.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn, input logic cinIn,
                               input int waits, input bit stallEn, input int stallPhase,
                               input bit ovrEn, input logic [31:0] ovrVal,
                               input bit pokeBusy, output int lat);
    int n;
    bit seen;
    @(negedge clk); #2;
    cfgWaits = waits; cfgStallEn = stallEn; cfgStallPhase = stallPhase;
    cfgOvrEn = ovrEn; cfgOvrVal = ovrVal;
    a = aIn; b = bIn; cin = cinIn; start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk); #2;
      start = 1'b0;
      if (n == 0) begin
        checkOutput("accept_busy", 32'(busy), 32'h1);
        checkOutput("accept_err_clear", 32'(err), 32'h0);
      end
      if (pokeBusy && (n == 2 || n == 5)) begin
        start = 1'b1; a = ~aIn; b = 16'h1357; cin = ~cinIn;
      end
      if (done) seen = 1'b1;
      else      n++;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen), 32'h1);
    lat = n;
  endtask

  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_cyc",  32'(cyc),  32'h0);
    checkOutput("reset_sum",  32'(sum),  32'h0);
    checkOutput("reset_err",  32'(err),  32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    $display("[TB] zero-wait 1234+4321");
    applyStimulus(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, lat);
    checkOutput("lat_zero_wait", 32'(lat), 32'd3);
    checkOutput("sum_5555", 32'(sum), 32'h5555);
    checkOutput("cout_0", 32'(cout), 32'h0);

    $display("[TB] forced read FFFF+0001+1");
    applyStimulus(16'hFFFF, 16'h0001, 1'b1, 0, 1'b0, 0, 1'b1, 32'h0001_0001, 1'b0, lat);
    checkOutput("sum_0001", 32'(sum), 32'h0001);
    checkOutput("cout_1", 32'(cout), 32'h1);
    checkOutput("mm_match", 32'(mm), 32'h0);

    $display("[TB] two wait states, start pokes while busy");
    applyStimulus(16'hAAAA, 16'h5555, 1'b1, 2, 1'b0, 0, 1'b0, 32'h0, 1'b1, lat);
    checkOutput("lat_two_waits", 32'(lat), 32'd9);
    checkOutput("sum_wrap", 32'(sum), 32'h0000);
    checkOutput("cout_wrap", 32'(cout), 32'h1);

    $display("[TB] stray acks while idle");
    @(negedge clk); #2 idleAck = 1'b1;
    repeat (3) @(negedge clk);
    #2 idleAck = 1'b0;
    checkOutput("idle_ack_busy", 32'(busy), 32'h0);

    $display("[TB] stall in WR_CIN");
    applyStimulus(16'h0F0F, 16'h00F0, 1'b0, 0, 1'b1, 1, 1'b0, 32'h0, 1'b0, lat);
    checkOutput("lat_timeout", 32'(lat), 32'd17);
    checkOutput("err_set", 32'(err), 32'h1);
    checkOutput("sum_kept", 32'(sum), 32'h0000);
    checkOutput("cout_kept", 32'(cout), 32'h1);

    $display("[TB] forced zero read 0001+0001");
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1, 1'b0, 0, 1'b1, 32'h0, 1'b0, lat);
    checkOutput("lat_one_wait", 32'(lat), 32'd6);
    checkOutput("err_cleared", 32'(err), 32'h0);
`ifdef LFA_WB_INITIATOR_CHECK_EN
    checkOutput("mm_detect", 32'(mm), 32'h1);
`else
    checkOutput("mm_detect", 32'(mm), 32'h0);
`endif

    $display("[TB] reset during RD_RES");
    @(negedge clk); #2;
    cfgWaits = 0; cfgStallEn = 1'b0; cfgOvrEn = 1'b0;
    a = 16'h0100; b = 16'h0200; cin = 1'b0; start = 1'b1;
    repeat (3) begin
      @(negedge clk); #2 start = 1'b0;
    end
    checkOutput("pre_rst_adr", adr, BASE + 32'h8);
    rst = 1'b1;
    #1;
    checkOutput("rst_cyc",  32'(cyc),  32'h0);
    checkOutput("rst_stb",  32'(stb),  32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    $display("[TB] recovery 7FFF+0001");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, lat);
    checkOutput("lat_recover", 32'(lat), 32'd3);
    checkOutput("sum_8000", 32'(sum), 32'h8000);

    repeat (2) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, errors so far %0d", errCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
